// File: rtl/bus_xfer_pkg.sv
// Shared encodings for the common-bus transfer sequencer: request opcodes, FSM states
// and the default register-bank geometry.
package bus_xfer_pkg;

    localparam int DEF_NREG   = 8;
    localparam int DEF_TR_IDX = 5;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_CLR  = 2'b01,
        OP_INC  = 2'b10,
        OP_SWAP = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SW1,
        ST_SW2,
        ST_SW3
    } state_t;

    // Slot 0 means "bus idle", so it can never be a real source or destination.
    function automatic logic idx_bad(input int idx, input int nreg);
        return (idx == 0) || (idx >= nreg);
    endfunction

endpackage

// File: rtl/bus_idx_decoder.sv
// Index plus enable to one-hot strobe vector for the register bank.
module bus_idx_decoder #(
    parameter int IDXW = 3,
    parameter int NREG = 8
) (
    input  logic [IDXW-1:0] idx,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == IDXW'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Register-transfer initiator: accepts MOV/CLR/INC/SWAP requests and drives the bus
// select plus one-hot LD/CLR/INC strobes, all straight from posedge flops.
module bus_xfer_sequencer
    import bus_xfer_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int IDXW   = $clog2(NREG),
    parameter int TR_IDX = DEF_TR_IDX
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [IDXW-1:0] req_src,
    input  logic [IDXW-1:0] req_dst,
    output logic [IDXW-1:0] bus_sel,
    output logic [NREG-1:0] ld,
    output logic [NREG-1:0] clr,
    output logic [NREG-1:0] inc,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [IDXW-1:0] TR_SEL = IDXW'(TR_IDX);

    state_t          state_reg, state_next;
    logic [IDXW-1:0] src_reg, src_next;
    logic [IDXW-1:0] dst_reg, dst_next;

    logic [IDXW-1:0] bus_sel_reg, bus_sel_next;
    logic [NREG-1:0] ld_reg, ld_next;
    logic [NREG-1:0] clr_reg, clr_next;
    logic [NREG-1:0] inc_reg, inc_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic [IDXW-1:0] strobe_idx;
    logic            ld_en, clr_en, inc_en;
    logic            accept, req_ok;

    assign accept = req_valid && (state_reg == ST_IDLE);

    always_comb begin
        req_ok = 1'b0;
        unique case (op_t'(req_op))
            OP_MOV:  req_ok = !idx_bad(int'(req_src), NREG) && !idx_bad(int'(req_dst), NREG);
            OP_CLR,
            OP_INC:  req_ok = !idx_bad(int'(req_dst), NREG);
            OP_SWAP: req_ok = !idx_bad(int'(req_src), NREG) && !idx_bad(int'(req_dst), NREG)
                              && (req_src != TR_SEL) && (req_dst != TR_SEL);
        endcase
    end

    // Outputs are computed one state ahead so the registered strobes line up with the state.
    always_comb begin
        state_next   = state_reg;
        src_next     = src_reg;
        dst_next     = dst_reg;
        bus_sel_next = '0;
        strobe_idx   = '0;
        ld_en        = 1'b0;
        clr_en       = 1'b0;
        inc_en       = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    src_next = req_src;
                    dst_next = req_dst;
                    if (!req_ok) begin
                        err_next = 1'b1;
                    end else begin
                        unique case (op_t'(req_op))
                            OP_MOV: begin
                                state_next   = ST_EXEC;
                                bus_sel_next = req_src;
                                strobe_idx   = req_dst;
                                ld_en        = 1'b1;
                                done_next    = 1'b1;
                            end
                            OP_CLR: begin
                                state_next = ST_EXEC;
                                strobe_idx = req_dst;
                                clr_en     = 1'b1;
                                done_next  = 1'b1;
                            end
                            OP_INC: begin
                                state_next = ST_EXEC;
                                strobe_idx = req_dst;
                                inc_en     = 1'b1;
                                done_next  = 1'b1;
                            end
                            OP_SWAP: begin
                                state_next   = ST_SW1;
                                bus_sel_next = req_src;
                                strobe_idx   = TR_SEL;
                                ld_en        = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_SW1: begin
                state_next   = ST_SW2;
                bus_sel_next = dst_reg;
                strobe_idx   = src_reg;
                ld_en        = 1'b1;
            end
            ST_SW2: begin
                state_next   = ST_SW3;
                bus_sel_next = TR_SEL;
                strobe_idx   = dst_reg;
                ld_en        = 1'b1;
                done_next    = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    bus_idx_decoder #(.IDXW(IDXW), .NREG(NREG)) u_ld_dec  (.idx(strobe_idx), .en(ld_en),  .onehot(ld_next));
    bus_idx_decoder #(.IDXW(IDXW), .NREG(NREG)) u_clr_dec (.idx(strobe_idx), .en(clr_en), .onehot(clr_next));
    bus_idx_decoder #(.IDXW(IDXW), .NREG(NREG)) u_inc_dec (.idx(strobe_idx), .en(inc_en), .onehot(inc_next));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            src_reg     <= '0;
            dst_reg     <= '0;
            bus_sel_reg <= '0;
            ld_reg      <= '0;
            clr_reg     <= '0;
            inc_reg     <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            src_reg     <= src_next;
            dst_reg     <= dst_next;
            bus_sel_reg <= bus_sel_next;
            ld_reg      <= ld_next;
            clr_reg     <= clr_next;
            inc_reg     <= inc_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign bus_sel   = bus_sel_reg;
    assign ld        = ld_reg;
    assign clr       = clr_reg;
    assign inc       = inc_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
